// File: rtl/alu_pkg.sv
// alu_pkg: opcode, state and selector definitions shared by the iterative ALU
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_OR   = 4'b0001, OP_AND = 4'b0010, OP_BNE  = 4'b0011,
        OP_SLT  = 4'b0100, OP_SUB  = 4'b0111, OP_SLL = 4'b1000, OP_XOR  = 4'b1001,
        OP_SRL  = 4'b1010, OP_BGEU = 4'b1011, OP_LUI = 4'b1100, OP_SLTU = 4'b1101,
        OP_SRA  = 4'b1110, OP_BEQ  = 4'b1111
    } base_op_e;
    typedef enum logic [2:0] {
        M_MUL = 3'b000, M_MULH = 3'b001, M_MULHSU = 3'b010, M_MULHU = 3'b011,
        M_DIV = 3'b100, M_DIVU = 3'b101, M_REM    = 3'b110, M_REMU  = 3'b111
    } m_op_e;
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;
    localparam logic BASE_SEL = 1'b0;
    localparam logic M_SEL    = 1'b1;
endpackage

// File: rtl/alu_mdiv_iter_if.sv
// alu_mdiv_iter_if: START/BUSY/DONE handshake with operand and result bus
// master drives start/control/x/y; slave returns resultado/zero/busy/done
interface alu_mdiv_iter_if #(parameter int WIDTH = 32);
    logic             start;
    logic [4:0]       control;
    logic [WIDTH-1:0] x, y, resultado;
    logic             zero, busy, done;
    modport master (output start, control, x, y, input resultado, zero, busy, done);
    modport slave  (input start, control, x, y, output resultado, zero, busy, done);
endinterface

// File: rtl/alu_base_w.sv
// alu_base_w: combinational evaluator for the base integer op set
// op: 4-bit base encoding; x, y: operands; r: result (0 for unused encodings)
module alu_base_w import alu_pkg::*; #(parameter int WIDTH = 32) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r
);
    localparam int SHAMT_W = $clog2(WIDTH);
    logic [SHAMT_W-1:0] sh;
    always_comb begin
        sh = y[SHAMT_W-1:0];
        case (base_op_e'(op))
            OP_ADD:  r = x + y;
            OP_LUI:  r = y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = WIDTH'($signed(x) < $signed(y));
            OP_SLTU: r = WIDTH'(x < y);
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $signed(x) >>> sh;
            OP_BGEU: r = WIDTH'(x >= y);
            OP_BEQ:  r = WIDTH'(x == y);
            OP_BNE:  r = WIDTH'(x != y);
            default: r = '0;
        endcase
    end
endmodule

// File: rtl/alu_mdiv_iter.sv
// alu_mdiv_iter: registered ALU with base ops in one cycle and bit-serial multiply/divide
// CLK/RESET: clock and synchronous active-high reset; bus: slave side of the handshake
module alu_mdiv_iter import alu_pkg::*; #(parameter int WIDTH = 32) (
    input logic            CLK,
    input logic            RESET,
    alu_mdiv_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_e             state, nxt;
    m_op_e              mop, op_q;
    logic [CW-1:0]      cnt;
    logic               neg_q, m_sel, sx, sy, dz, ovf, quick;
    logic [WIDTH-1:0]   b_q, ax, ay, base_r, spec_r, dv, fin_r, res_n;
    logic [WIDTH:0]     msum, rcand, rdiff;
    logic [2*WIDTH-1:0] acc, prod;

    alu_base_w #(.WIDTH(WIDTH)) u_base (.op(bus.control[3:0]), .x(bus.x), .y(bus.y), .r(base_r));

    always_comb begin
        mop = m_op_e'(bus.control[2:0]);
        m_sel = bus.control[4] == M_SEL;
        sx = mop inside {M_MULH, M_MULHSU, M_DIV, M_REM} && bus.x[WIDTH-1];
        sy = mop inside {M_MULH, M_DIV, M_REM} && bus.y[WIDTH-1];
        ax = sx ? -bus.x : bus.x;
        ay = sy ? -bus.y : bus.y;
        // divide-by-zero and signed overflow finish immediately like base ops
        dz = mop[2] && bus.y == '0;
        ovf = mop[2] && !mop[0] && bus.x == MIN && bus.y == '1;
        quick = !m_sel || dz || ovf;
        spec_r = dz ? (mop[1] ? bus.x : '1) : (mop[1] ? '0 : bus.x);
        // multiply: acc = {partial high, remaining multiplier bits}
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        // divide: acc = {partial remainder, dividend bits shifting into quotient}
        rcand = acc[2*WIDTH-1:WIDTH-1];
        rdiff = rcand - {1'b0, b_q};
        prod = neg_q ? -acc : acc;
        dv = op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        fin_r = op_q[2] ? (neg_q ? -dv : dv) : (op_q == M_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
        res_n = state == FIN ? fin_r : (m_sel ? spec_r : base_r);
    end

    always_ff @(posedge CLK) state <= RESET ? IDLE : nxt;

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (bus.start && !quick ? CALC : IDLE) :
              state == CALC ? (cnt == CW'(1) ? FIN : CALC) : IDLE;
    end

    assign bus.busy = state != IDLE;

    always_ff @(posedge CLK) begin
        bus.done <= 1'b0;
        if (RESET) begin
            bus.resultado <= '0;
            bus.zero <= 1'b0;
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            acc <= op_q[2] ? (rdiff[WIDTH] ? {rcand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                           : {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                           : {msum, acc[WIDTH-1:1]};
        end else if (state == FIN || (bus.start && quick)) begin
            bus.resultado <= res_n;
            bus.zero <= res_n == WIDTH'(1);
            bus.done <= 1'b1;
        end else if (bus.start) begin
            op_q <= mop;
            neg_q <= mop[2] && mop[1] ? sx : sx ^ sy;
            b_q <= ay;
            acc <= {{WIDTH{1'b0}}, ax};
            cnt <= CW'(WIDTH);
        end
    end
endmodule
